// File: rtl/parity_engine_afu.sv
// Parity engine AFU: MMIO-visible data registers with per-word parity, a write
// counter and a sticky bad-access flag, gated by a START/RESET job FSM.
package parity_engine_afu_pkg;
  typedef struct packed {
    logic       valid;
    logic [7:0] command;
  } JobInterfaceInput;

  typedef struct packed {
    logic        running;
    logic        done;
    logic        cack;
    logic [63:0] error;
    logic        yield;
  } JobInterfaceOutput;

  typedef struct packed {
    logic        valid;
    logic        read;
    logic        doubleword;
    logic [23:0] address;
    logic [63:0] data;
  } MMIOInterfaceInput;

  typedef struct packed {
    logic        ack;
    logic [63:0] data;
  } MMIOInterfaceOutput;

  typedef struct packed {
    logic [7:0] room;
  } CommandInterfaceInput;

  typedef struct packed {
    logic        valid;
    logic [7:0]  tag;
    logic [12:0] command;
    logic [63:0] address;
    logic [11:0] size;
  } CommandInterfaceOutput;

  typedef struct packed {
    logic         read_valid;
    logic [7:0]   read_tag;
    logic [5:0]   read_address;
    logic         write_valid;
    logic [7:0]   write_tag;
    logic [5:0]   write_address;
    logic [511:0] write_data;
  } BufferInterfaceInput;

  typedef struct packed {
    logic [3:0]   read_latency;
    logic [511:0] read_data;
  } BufferInterfaceOutput;

  typedef struct packed {
    logic       valid;
    logic [7:0] tag;
    logic [7:0] response;
  } ResponseInterface;
endpackage

module parity_engine_afu
  import parity_engine_afu_pkg::*;
#(
  parameter int unsigned WORDS      = 4,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  timebase_request,
  output logic                  parity_enabled,
  input  JobInterfaceInput      job_in,
  output JobInterfaceOutput     job_out,
  input  MMIOInterfaceInput     mmio_in,
  output MMIOInterfaceOutput    mmio_out,
  input  CommandInterfaceInput  command_in,
  output CommandInterfaceOutput command_out,
  input  BufferInterfaceInput   buffer_in,
  output BufferInterfaceOutput  buffer_out,
  input  ResponseInterface      response
);

  localparam int unsigned      IDX_W     = 23;
  localparam logic [IDX_W-1:0] P_IDX     = IDX_W'(WORDS);
  localparam logic [IDX_W-1:0] S_IDX     = IDX_W'(WORDS + 1);
  localparam logic [7:0]       CMD_START = 8'h90;
  localparam logic [7:0]       CMD_RESET = 8'h80;

  typedef enum logic [1:0] { IDLE, RUNNING, DONE } state_e;

  state_e            state_q, state_d;
  logic [63:0]       data_q [WORDS];
  logic [63:0]       data_d [WORDS];
  logic [WORDS-1:0]  par_q, par_d;
  logic [31:0]       wcnt_q, wcnt_d;
  logic              bad_q, bad_d;
  logic              running_q, done_q, ack_q;
  logic [63:0]       rdata_q, rdata_d;

  logic [IDX_W-1:0]  idx;
  logic              reset_cmd, start_cmd, rd_req, wr_req, is_bad;
  logic [63:0]       cur_word, reg_val, new_word;
  logic              unused_inputs;

  assign idx       = mmio_in.address[23:1];
  assign reset_cmd = job_in.valid && (job_in.command == CMD_RESET);
  assign start_cmd = job_in.valid && (job_in.command == CMD_START);
  assign rd_req    = mmio_in.valid && mmio_in.read;
  // RESET in the same cycle drops the write; the ack is still produced.
  assign wr_req    = mmio_in.valid && !mmio_in.read && (state_q == RUNNING) && !reset_cmd;
  assign is_bad    = idx > S_IDX;

  // Register file read mux and merged write word for half-width writes
  always_comb begin
    cur_word = '0;
    for (int i = 0; i < int'(WORDS); i++) begin
      if (idx == IDX_W'(i)) cur_word = data_q[i];
    end
    reg_val = cur_word;
    if (idx == P_IDX)      reg_val = 64'(par_q);
    else if (idx == S_IDX) reg_val = {31'b0, bad_q, wcnt_q};
    new_word = mmio_in.doubleword ? mmio_in.data : {cur_word[63:32], mmio_in.data[31:0]};
  end

  // Next-state logic for the job FSM and the register file
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    par_d   = par_q;
    wcnt_d  = wcnt_q;
    bad_d   = bad_q;
    rdata_d = '0;

    case (state_q)
      IDLE:    if (start_cmd) state_d = RUNNING;
      DONE:    state_d = IDLE;
      default: ;
    endcase

    if (rd_req) begin
      if (mmio_in.doubleword)      rdata_d = reg_val;
      else if (mmio_in.address[0]) rdata_d = {32'b0, reg_val[63:32]};
      else                         rdata_d = {32'b0, reg_val[31:0]};
    end

    if (mmio_in.valid && is_bad) bad_d = 1'b1;

    if (wr_req) begin
      for (int i = 0; i < int'(WORDS); i++) begin
        if (idx == IDX_W'(i)) begin
          data_d[i] = new_word;
          par_d[i]  = (^new_word) ^ PARITY_ODD;
          if (wcnt_q != '1) wcnt_d = wcnt_q + 32'd1;
        end
      end
    end

    if (reset_cmd) begin
      state_d = DONE;
      for (int i = 0; i < int'(WORDS); i++) data_d[i] = '0;
      par_d  = '0;
      wcnt_d = '0;
      bad_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      for (int i = 0; i < int'(WORDS); i++) data_q[i] <= '0;
      par_q     <= '0;
      wcnt_q    <= '0;
      bad_q     <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_q     <= par_d;
      wcnt_q    <= wcnt_d;
      bad_q     <= bad_d;
      running_q <= (state_d == RUNNING);
      done_q    <= (state_d == DONE);
      ack_q     <= mmio_in.valid;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    job_out         = '0;
    job_out.running = running_q;
    job_out.done    = done_q;
    job_out.error   = {63'b0, bad_q};
    mmio_out        = '0;
    mmio_out.ack    = ack_q;
    mmio_out.data   = rdata_q;
    command_out     = '0;
    buffer_out      = '0;
  end

  assign timebase_request = 1'b0;
  assign parity_enabled   = 1'b0;
  assign unused_inputs    = ^{command_in, buffer_in, response};

endmodule

// File: tb/tb_parity_engine_afu.sv
// Bench for parity_engine_afu: two instances (4 words even, 8 words odd) sharing
// job_in, checked against a register-level behavioural model.
module tb_parity_engine_afu;
  import parity_engine_afu_pkg::*;

  localparam logic [7:0] CMD_START = 8'h90;
  localparam logic [7:0] CMD_RESET = 8'h80;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  JobInterfaceInput      job_in;
  MMIOInterfaceInput     mi [2];
  JobInterfaceOutput     jo [2];
  MMIOInterfaceOutput    mo [2];
  CommandInterfaceOutput co [2];
  BufferInterfaceOutput  bo [2];
  logic                  tb_req [2];
  logic                  par_en [2];
  CommandInterfaceInput  cmd_in = '0;
  BufferInterfaceInput   buf_in = '0;
  ResponseInterface      rsp    = '0;

  parity_engine_afu #(.WORDS(4), .PARITY_ODD(1'b0)) dut0 (
    .clock(clk), .reset_n(rst_n), .timebase_request(tb_req[0]), .parity_enabled(par_en[0]),
    .job_in(job_in), .job_out(jo[0]), .mmio_in(mi[0]), .mmio_out(mo[0]),
    .command_in(cmd_in), .command_out(co[0]), .buffer_in(buf_in), .buffer_out(bo[0]),
    .response(rsp));

  parity_engine_afu #(.WORDS(8), .PARITY_ODD(1'b1)) dut1 (
    .clock(clk), .reset_n(rst_n), .timebase_request(tb_req[1]), .parity_enabled(par_en[1]),
    .job_in(job_in), .job_out(jo[1]), .mmio_in(mi[1]), .mmio_out(mo[1]),
    .command_in(cmd_in), .command_out(co[1]), .buffer_in(buf_in), .buffer_out(bo[1]),
    .response(rsp));

  // Reference model state
  int unsigned MW   [2] = '{4, 8};
  bit          MODD [2] = '{1'b0, 1'b1};
  logic [63:0] m_d   [2][32];
  logic [31:0] m_p   [2];
  logic [31:0] m_cnt [2];
  bit          m_bad [2];
  bit          m_run;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) m_d[k][i] = 64'h0;
      m_p[k]   = 32'h0;
      m_cnt[k] = 32'h0;
      m_bad[k] = 1'b0;
    end
    m_run = 1'b0;
  endfunction

  // Applies one MMIO access to the model and returns the expected read data.
  function automatic logic [63:0] model_access(input int k, input bit rd, input bit dw,
                                               input int unsigned ix, input bit hi,
                                               input logic [63:0] wd, input bit rst_cmd);
    logic [63:0] cur, nw, r;
    int unsigned w;
    w   = MW[k];
    cur = 64'h0;
    if (ix < w)           cur = m_d[k][ix];
    else if (ix == w)     cur = {32'h0, m_p[k]};
    else if (ix == w + 1) cur = {31'h0, m_bad[k], m_cnt[k]};
    r = 64'h0;
    if (rd) r = dw ? cur : (hi ? (cur >> 32) : (cur & 64'hFFFF_FFFF));
    if (ix > w + 1) m_bad[k] = 1'b1;
    if (!rd && m_run && !rst_cmd && ix < w) begin
      nw = dw ? wd : {cur[63:32], wd[31:0]};
      m_d[k][ix] = nw;
      m_p[k][ix] = (($countones(nw) % 2) == 1) != MODD[k];
      if (m_cnt[k] != 32'hFFFF_FFFF) m_cnt[k] = m_cnt[k] + 32'd1;
    end
    if (rst_cmd) model_clear();
    return r;
  endfunction

  task automatic do_access(input int k, input bit rd, input bit dw, input int unsigned ix,
                           input bit hi, input logic [63:0] wd, input bit rst_cmd,
                           output logic [63:0] obs);
    logic [63:0] exp;
    @(negedge clk);
    mi[k].valid      = 1'b1;
    mi[k].read       = rd;
    mi[k].doubleword = dw;
    mi[k].address    = {23'(ix), hi};
    mi[k].data       = wd;
    if (rst_cmd) begin
      job_in.valid   = 1'b1;
      job_in.command = CMD_RESET;
    end
    exp = model_access(k, rd, dw, ix, hi, wd, rst_cmd);
    @(posedge clk); #1;
    mi[k]  = '0;
    job_in = '0;
    obs    = mo[k].data;
    n_checks++;
    if (mo[k].ack !== 1'b1) begin
      n_errors++; $display("FAIL ack k=%0d idx=%0d: got %b want 1", k, ix, mo[k].ack);
    end
    if (rd) begin
      n_checks++;
      if (mo[k].data !== exp) begin
        n_errors++;
        $display("FAIL rdata k=%0d idx=%0d dw=%0d hi=%0d: got %h want %h", k, ix, dw, hi, mo[k].data, exp);
      end
    end
    n_checks++;
    if (jo[k].error !== {63'h0, m_bad[k]}) begin
      n_errors++; $display("FAIL error k=%0d: got %h want %0d", k, jo[k].error, m_bad[k]);
    end
    if (rst_cmd) begin
      n_checks++;
      if (jo[k].done !== 1'b1 || jo[k].running !== 1'b0) begin
        n_errors++; $display("FAIL reset_done k=%0d: done=%b running=%b want 1/0", k, jo[k].done, jo[k].running);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (mo[k].ack !== 1'b0 || mo[k].data !== 64'h0) begin
      n_errors++; $display("FAIL idle_ack k=%0d: ack=%b data=%h want 0/0", k, mo[k].ack, mo[k].data);
    end
    if (rst_cmd) begin
      n_checks++;
      if (jo[k].done !== 1'b0) begin
        n_errors++; $display("FAIL done_width k=%0d: got %b want 0", k, jo[k].done);
      end
    end
  endtask

  task automatic send_cmd(input logic [7:0] cmd);
    bit exp_done;
    @(negedge clk);
    job_in.valid   = 1'b1;
    job_in.command = cmd;
    exp_done = (cmd == CMD_RESET);
    if (cmd == CMD_RESET) model_clear();
    else if (cmd == CMD_START) m_run = 1'b1;
    @(posedge clk); #1;
    job_in = '0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (jo[k].running !== m_run || jo[k].done !== exp_done) begin
        n_errors++;
        $display("FAIL cmd %h k=%0d: running=%b done=%b want %b/%b", cmd, k, jo[k].running, jo[k].done, m_run, exp_done);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (jo[k].done !== 1'b0 || jo[k].running !== m_run) begin
        n_errors++;
        $display("FAIL cmd_after %h k=%0d: running=%b done=%b want %b/0", cmd, k, jo[k].running, jo[k].done, m_run);
      end
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    job_in = '0;
    mi[0]  = '0;
    mi[1]  = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (jo[k] !== '0 || mo[k] !== '0 || tb_req[k] !== 1'b0 || par_en[k] !== 1'b0 ||
          co[k] !== '0 || bo[k] !== '0) begin
        n_errors++; $display("FAIL reset_state k=%0d: job_out=%h mmio_out=%h want 0", k, jo[k], mo[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (jo[k] !== '0 || mo[k] !== '0) begin
        n_errors++; $display("FAIL post_reset k=%0d: job_out=%h mmio_out=%h want 0", k, jo[k], mo[k]);
      end
    end
  endtask

  task automatic test_idle_write();
    logic [63:0] obs;
    do_access(0, 1'b0, 1'b1, 0, 1'b0, 64'hDEAD_BEEF_0123_4567, 1'b0, obs);
    do_access(0, 1'b1, 1'b1, 0, 1'b0, 64'h0, 1'b0, obs);
    n_checks++;
    if (obs !== 64'h0) begin n_errors++; $display("FAIL idle_d0: got %h want 0", obs); end
    do_access(0, 1'b1, 1'b1, 5, 1'b0, 64'h0, 1'b0, obs);
    n_checks++;
    if (obs !== 64'h0) begin n_errors++; $display("FAIL idle_count: got %h want 0", obs); end
  endtask

  task automatic test_basic();
    logic [63:0] obs;
    send_cmd(CMD_START);
    do_access(0, 1'b0, 1'b1, 0, 1'b0, 64'h1, 1'b0, obs);
    do_access(0, 1'b1, 1'b1, 4, 1'b0, 64'h0, 1'b0, obs);
    n_checks++;
    if (obs !== 64'h1) begin n_errors++; $display("FAIL basic_parity: got %h want 1", obs); end
    do_access(0, 1'b1, 1'b1, 5, 1'b0, 64'h0, 1'b0, obs);
    n_checks++;
    if (obs !== 64'h1) begin n_errors++; $display("FAIL basic_status: got %h want 1", obs); end
  endtask

  task automatic test_half_write();
    logic [63:0] obs;
    do_access(0, 1'b0, 1'b1, 1, 1'b0, 64'hA5A5_0000_0000_0000, 1'b0, obs);
    do_access(0, 1'b0, 1'b0, 1, 1'b0, 64'h1234_5678_FFFF_FFFF, 1'b0, obs);
    do_access(0, 1'b1, 1'b1, 1, 1'b0, 64'h0, 1'b0, obs);
    n_checks++;
    if (obs !== 64'hA5A5_0000_FFFF_FFFF) begin n_errors++; $display("FAIL half_write: got %h want a5a50000ffffffff", obs); end
    do_access(0, 1'b1, 1'b0, 1, 1'b1, 64'h0, 1'b0, obs);
    n_checks++;
    if (obs !== 64'h0000_0000_A5A5_0000) begin n_errors++; $display("FAIL half_read_hi: got %h want a5a50000", obs); end
  endtask

  task automatic test_parity_odd();
    logic [63:0] obs;
    do_access(1, 1'b0, 1'b1, 7, 1'b0, 64'h3, 1'b0, obs);
    do_access(1, 1'b1, 1'b1, 8, 1'b0, 64'h0, 1'b0, obs);
    n_checks++;
    if (obs !== 64'h80) begin n_errors++; $display("FAIL odd_parity: got %h want 80", obs); end
  endtask

  task automatic test_bad_index();
    logic [63:0] obs;
    do_access(0, 1'b0, 1'b1, 6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, obs);
    n_checks++;
    if (jo[0].error !== 64'h1) begin n_errors++; $display("FAIL bad_error: got %h want 1", jo[0].error); end
    do_access(0, 1'b1, 1'b1, 5, 1'b0, 64'h0, 1'b0, obs);
    n_checks++;
    if (obs !== 64'h0000_0001_0000_0003) begin n_errors++; $display("FAIL bad_status: got %h want 100000003", obs); end
    do_access(0, 1'b1, 1'b1, 0, 1'b0, 64'h0, 1'b0, obs);
    n_checks++;
    if (obs !== 64'h1) begin n_errors++; $display("FAIL bad_nochange: got %h want 1", obs); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] wd [3];
    logic [63:0] obs;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      wd[j] = {$urandom, $urandom};
      mi[0].valid      = 1'b1;
      mi[0].read       = 1'b0;
      mi[0].doubleword = 1'b1;
      mi[0].address    = {23'(j), 1'b0};
      mi[0].data       = wd[j];
      void'(model_access(0, 1'b0, 1'b1, j, 1'b0, wd[j], 1'b0));
      @(posedge clk); #1;
      n_checks++;
      if (mo[0].ack !== 1'b1) begin n_errors++; $display("FAIL b2b_ack %0d: got %b want 1", j, mo[0].ack); end
    end
    mi[0] = '0;
    @(posedge clk); #1;
    n_checks++;
    if (mo[0].ack !== 1'b0) begin n_errors++; $display("FAIL b2b_ack_end: got %b want 0", mo[0].ack); end
    for (int j = 0; j < 3; j++) begin
      do_access(0, 1'b1, 1'b1, j, 1'b0, 64'h0, 1'b0, obs);
      n_checks++;
      if (obs !== wd[j]) begin n_errors++; $display("FAIL b2b_data %0d: got %h want %h", j, obs, wd[j]); end
    end
  endtask

  task automatic test_reset_collision();
    logic [63:0] obs;
    send_cmd(8'h33);
    do_access(0, 1'b0, 1'b1, 0, 1'b0, 64'hFFFF_0000_FFFF_0000, 1'b1, obs);
    n_checks++;
    if (jo[0].running !== 1'b0) begin n_errors++; $display("FAIL collide_running: got %b want 0", jo[0].running); end
    do_access(0, 1'b1, 1'b1, 0, 1'b0, 64'h0, 1'b0, obs);
    n_checks++;
    if (obs !== 64'h0) begin n_errors++; $display("FAIL collide_d0: got %h want 0", obs); end
  endtask

  task automatic test_random();
    logic [63:0] obs;
    int unsigned r, k, ix;
    send_cmd(CMD_START);
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 39);
      if (r == 0)      send_cmd(CMD_RESET);
      else if (r <= 2) send_cmd(CMD_START);
      else if (r == 3) send_cmd(8'($urandom_range(0, 127)));
      else begin
        k  = $urandom_range(0, 1);
        ix = $urandom_range(0, MW[k] + 3);
        do_access(int'(k), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ix,
                  1'($urandom_range(0, 1)), {$urandom, $urandom}, (r == 4), obs);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] obs;
    if (!m_run) send_cmd(CMD_START);
    @(negedge clk);
    mi[0].valid      = 1'b1;
    mi[0].read       = 1'b1;
    mi[0].doubleword = 1'b1;
    mi[0].address    = 24'h0;
    @(posedge clk); #1;
    mi[0] = '0;
    n_checks++;
    if (mo[0].ack !== 1'b1) begin n_errors++; $display("FAIL async_pre_ack: got %b want 1", mo[0].ack); end
    rst_n = 1'b0;
    #1;
    model_clear();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (mo[k].ack !== 1'b0 || jo[k].running !== 1'b0) begin
        n_errors++; $display("FAIL async_reset k=%0d: ack=%b running=%b want 0/0", k, mo[k].ack, jo[k].running);
      end
    end
    @(negedge clk);
    rst_n          = 1'b1;
    job_in.valid   = 1'b1;
    job_in.command = CMD_START;
    m_run          = 1'b1;
    @(posedge clk); #1;
    job_in = '0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (jo[k].running !== 1'b1) begin n_errors++; $display("FAIL first_edge_start k=%0d: got %b want 1", k, jo[k].running); end
    end
    do_access(0, 1'b1, 1'b1, 0, 1'b0, 64'h0, 1'b0, obs);
    do_access(1, 1'b1, 1'b1, 9, 1'b0, 64'h0, 1'b0, obs);
  endtask

  initial begin
    test_reset();
    test_idle_write();
    test_basic();
    test_half_write();
    test_parity_odd();
    test_bad_index();
    test_back_to_back();
    test_reset_collision();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/parity_engine_afu.md
PARITY_ENGINE_AFU -- requirements
Module: parity_engine_afu

Interface
REQ-001 SHALL have parameter WORDS, default 4, giving the number of MMIO data registers (legal range 1..32).
REQ-002 SHALL have parameter PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports timebase_request and parity_enabled, output, 1 each, both tied to 0.
REQ-006 SHALL have port job_in, input, JobInterfaceInput; fields used: valid, command[7:0].
REQ-007 SHALL have port job_out, output, JobInterfaceOutput; fields driven: running, done, cack (0), error[63:0], yield (0).
REQ-008 SHALL have port mmio_in, input, MMIOInterfaceInput; fields used: valid, read, doubleword, address[23:0], data[63:0].
REQ-009 SHALL have port mmio_out, output, MMIOInterfaceOutput; fields driven: ack, data[63:0].
REQ-010 SHALL have ports command_in/command_out, buffer_in/buffer_out and response present; all outputs are tied to 0 and all inputs ignored.

Function
REQ-011 SHALL implement a job FSM with states IDLE, RUNNING, DONE.
REQ-012 IDLE: job_in.valid with command 8'h90 (START) SHALL go to RUNNING; job_out.running SHALL be 1 from the next cycle.
REQ-013 In any state, job_in.valid with command 8'h80 (RESET) SHALL go to DONE, clear all data, parity and status registers, and drop running.
REQ-014 DONE SHALL assert job_out.done for exactly one cycle, then return to IDLE.
REQ-015 Other commands SHALL be ignored in every state.
REQ-016 Every mmio_in.valid pulse SHALL produce mmio_out.ack exactly one cycle later, for one cycle, in all states.
REQ-017 Register index = address[23:1]. Index 0..WORDS-1 SHALL be data registers D[i], 64-bit. Index WORDS SHALL be parity P, with bits [WORDS-1:0] and the rest 0. Index WORDS+1 SHALL be status S.
REQ-018 S SHALL hold the write count in [31:0] (saturating at 32'hFFFF_FFFF) and a sticky bad-access flag in [32]; other bits are 0.
REQ-019 A write to D[i] in RUNNING with doubleword=1 SHALL load all 64 bits. With doubleword=0 it SHALL load data[31:0] into bits [31:0] and leave bits [63:32] unchanged.
REQ-020 P[i] SHALL update in the same cycle D[i] loads: XOR-reduce of the new D[i], XOR PARITY_ODD.
REQ-021 Every accepted data-register write SHALL increment the write count by 1.
REQ-022 Writes to P or S SHALL be ignored but acked.
REQ-023 Reads SHALL return the register in mmio_out.data in the ack cycle. With doubleword=0, address[0]=1 SHALL return bits [63:32] in [31:0]; otherwise bits [31:0] in [31:0], upper half 0.
REQ-024 Any MMIO access outside IDLE/RUNNING/DONE validity rules SHALL be acked with no state change:
  - a write outside RUNNING is ignored;
  - reads in any state return current contents.
REQ-025 An index greater than WORDS+1 SHALL set S[32] and job_out.error[0]. Reads return 64'h0 and writes are ignored.
REQ-026 If a RESET command and an MMIO write land in the same cycle, RESET SHALL win: the write is dropped but still acked.
REQ-027 mmio_out.data SHALL be 0 in all non-ack cycles.

Reset
REQ-028 While reset_n=0, SHALL asynchronously force the FSM to IDLE and set all of D, P, S, job_out.* and mmio_out.* to 0.
REQ-029 A reset mid-access SHALL suppress a pending ack.
REQ-030 After reset_n rises, the block SHALL respond to job_in from the first clock edge.

Verification
REQ-031 Reset, START, then write D[0]=64'h1 (doubleword) -> ack after 1 cycle; read P -> 64'h1; read S -> 64'h1.
REQ-032 PARITY_ODD=1, WORDS=8: write D[7]=64'h3 -> P[7]=1 and the other P bits 0.
REQ-033 32-bit write of 32'hFFFF_FFFF to D[1] preloaded with 64'hA5A5_0000_0000_0000 -> D[1] reads back 64'hA5A5_0000_FFFF_FFFF.
REQ-034 Write to index WORDS+2 -> ack; S[32]=1; job_out.error=64'h1; no D change.
REQ-035 RESET in the same cycle as a write of D[0] -> D[0]=0, done pulses 1 cycle, running=0, ack still seen.
REQ-036 Write while IDLE (no START) -> acked; a read returns 0; write count stays 0.
